// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and constants for the memory arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    localparam logic        SEL_ICACHE       = 1'b0;
    localparam logic        SEL_DCACHE       = 1'b1;
    localparam logic [15:0] BLOCK_MASK       = 16'hFFF0;
    localparam int          DEF_MEM_LATENCY  = 4;
    localparam int          DEF_BLOCK_WORDS  = 8;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Cache-miss / write-through / memory bus bundle for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;

    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        w_req;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        i_stall;
    logic        d_stall;
    logic        w_ack;
    logic        fill_sel;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        fill_data_we;
    logic        fill_tag_we;

    // Arbiter side
    modport master (
        input  i_req, i_addr, d_req, d_addr, w_req, w_addr, w_data,
               mem_rdata, mem_valid,
        output mem_addr, mem_enable, mem_wr, mem_wdata, i_stall, d_stall,
               w_ack, fill_sel, fill_word, fill_data, fill_data_we, fill_tag_we
    );

    // Caches and memory side
    modport slave (
        output i_req, i_addr, d_req, d_addr, w_req, w_addr, w_data,
               mem_rdata, mem_valid,
        input  mem_addr, mem_enable, mem_wr, mem_wdata, i_stall, d_stall,
               w_ack, fill_sel, fill_word, fill_data, fill_data_we, fill_tag_we
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_fill_counter.sv
`default_nettype none
// ============================================================================
// Module   : fill_counter
// Brief    : Issue and return word counters for one block fill.
// Revision : 1.0 - initial release
// ============================================================================
module fill_counter
    import mem_pkg::*;
#(
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_clear,
    input  wire logic       i_issue,
    input  wire logic       i_ret,
    output logic [2:0]      o_issue_cnt,
    output logic            o_issue_done,
    output logic [2:0]      o_ret_cnt,
    output logic            o_ret_done,
    output logic            o_ret_last
);

    localparam logic [2:0] c_LAST = 3'(BLOCK_WORDS - 1);

    // Counters saturate at the last word and raise a done flag instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_issue_cnt  <= 3'd0;
            o_issue_done <= 1'b0;
            o_ret_cnt    <= 3'd0;
            o_ret_done   <= 1'b0;
        end else if (i_clear) begin
            o_issue_cnt  <= 3'd0;
            o_issue_done <= 1'b0;
            o_ret_cnt    <= 3'd0;
            o_ret_done   <= 1'b0;
        end else begin
            if (i_issue && !o_issue_done) begin
                if (o_issue_cnt == c_LAST) o_issue_done <= 1'b1;
                else                       o_issue_cnt  <= o_issue_cnt + 3'd1;
            end
            if (i_ret && !o_ret_done) begin
                if (o_ret_cnt == c_LAST) o_ret_done <= 1'b1;
                else                     o_ret_cnt  <= o_ret_cnt + 3'd1;
            end
        end
    end

    assign o_ret_last = i_ret && !o_ret_done && (o_ret_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between I/D block fills and D write-through.
//            Define ARB_RR_EN for round-robin on simultaneous I/D misses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_arbiter_if.master  bus
);

    if (MEM_LATENCY < 1 || BLOCK_WORDS < 1 || BLOCK_WORDS > 8) begin : g_param_check
        $error("mem_arbiter: unsupported MEM_LATENCY/BLOCK_WORDS");
    end

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic [15:0] r_base;
    logic        r_sel;
    logic        w_start_fill;
    logic        w_grant_sel;
    logic        w_in_fill;
    logic        w_writing;
    logic        w_reading;
    logic        w_ret;
    logic        w_fill_we;
    logic        w_tag_we;
    logic [2:0]  w_issue_cnt;
    logic        w_issue_done;
    logic [2:0]  w_ret_cnt;
    logic        w_ret_done;
    logic        w_ret_last;

`ifdef ARB_RR_EN
    logic r_last_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              r_last_sel <= SEL_ICACHE;
        else if (w_start_fill) r_last_sel <= w_grant_sel;
    end

    always_comb begin
        w_grant_sel = bus.d_req ? SEL_DCACHE : SEL_ICACHE;
        if (bus.d_req && bus.i_req) w_grant_sel = ~r_last_sel;
    end
`else
    always_comb begin
        w_grant_sel = bus.d_req ? SEL_DCACHE : SEL_ICACHE;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Pending writes always beat misses so write-through never starves
    always_comb begin
        w_state_nxt  = r_state;
        w_start_fill = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.w_req) begin
                    w_state_nxt = ST_WRITE;
                end else if (bus.d_req || bus.i_req) begin
                    w_state_nxt  = ST_FILL;
                    w_start_fill = 1'b1;
                end
            end
            ST_FILL:  if (w_ret_last) w_state_nxt = ST_IDLE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base <= 16'h0000;
            r_sel  <= SEL_ICACHE;
        end else if (w_start_fill) begin
            r_base <= (w_grant_sel ? bus.d_addr : bus.i_addr) & BLOCK_MASK;
            r_sel  <= w_grant_sel;
        end
    end

    fill_counter #(
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_fill_counter (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_fill),
        .i_issue      (w_in_fill),
        .i_ret        (w_ret),
        .o_issue_cnt  (w_issue_cnt),
        .o_issue_done (w_issue_done),
        .o_ret_cnt    (w_ret_cnt),
        .o_ret_done   (w_ret_done),
        .o_ret_last   (w_ret_last)
    );

    assign w_in_fill = (r_state == ST_FILL);
    assign w_writing = (r_state == ST_WRITE);
    assign w_reading = w_in_fill && !w_issue_done;
    assign w_ret     = w_in_fill && bus.mem_valid;
    assign w_fill_we = w_ret && !w_ret_done;
    assign w_tag_we  = w_ret_last;

    assign bus.mem_enable   = w_writing || w_reading;
    assign bus.mem_wr       = w_writing;
    assign bus.mem_addr     = w_writing ? bus.w_addr :
                              w_reading ? (r_base + {12'd0, w_issue_cnt, 1'b0}) : 16'h0000;
    assign bus.mem_wdata    = w_writing ? bus.w_data : 16'h0000;
    assign bus.w_ack        = w_writing;
    assign bus.fill_sel     = r_sel;
    assign bus.fill_word    = w_fill_we ? w_ret_cnt : 3'd0;
    assign bus.fill_data    = w_fill_we ? bus.mem_rdata : 16'h0000;
    assign bus.fill_data_we = w_fill_we;
    assign bus.fill_tag_we  = w_tag_we;

    // Stalls follow the raw requests, so force them low while reset is held
    assign bus.i_stall = rst && bus.i_req && !(w_tag_we && (r_sel == SEL_ICACHE));
    assign bus.d_stall = rst && ((bus.d_req && !(w_tag_we && (r_sel == SEL_DCACHE)))
                                 || (bus.w_req && !w_writing));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a fixed-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int c_LAT = 4;
    localparam int c_BW  = 8;

    typedef struct packed {
        logic        sel;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_exp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MEM_LATENCY (c_LAT),
        .BLOCK_WORDS (c_BW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int        n_chk = 0;
    int        n_err = 0;
    int        cyc   = 0;
    int        n_issue = 0;
    int        first_issue = 0;
    int        last_word = -1;
    int        n_fdwe = 0;
    int        tag_cyc = 0;
    int        write_cyc = 0;
    fill_exp_t fill_q[$];
    wr_exp_t   wr_q[$];

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Memory: each read issued in cycle c returns in cycle c+c_LAT
    logic [c_LAT-1:0] r_pv = '0;
    logic [15:0]      r_pa [c_LAT];
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        r_pv <= {r_pv[c_LAT-2:0], bus.mem_enable & ~bus.mem_wr};
        r_pa[0] <= bus.mem_addr;
        for (int i = 1; i < c_LAT; i++) r_pa[i] <= r_pa[i-1];
    end
    assign bus.mem_valid = r_pv[c_LAT-1];
    assign bus.mem_rdata = r_pv[c_LAT-1] ? mem_fn(r_pa[c_LAT-1]) : 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_fill(input logic sel, input logic [15:0] addr, input int nwords);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < nwords; k++)
            fill_q.push_back('{sel: sel, word: 3'(k), data: mem_fn(base + 16'(2 * k))});
    endtask

    task automatic monitor();
        fill_exp_t f;
        wr_exp_t   w;
        if (!rst) begin
            n_issue = 0;
            return;
        end
        if (bus.mem_enable && !bus.mem_wr) begin
            if (n_issue == 0) first_issue = cyc;
            n_issue++;
        end
        if (bus.mem_enable && bus.mem_wr) begin
            write_cyc = cyc;
            if (wr_q.size() == 0) check_eq("unexpected_write", 32'(bus.mem_addr), 32'hFFFFFFFF);
            else begin
                w = wr_q.pop_front();
                check_eq("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                check_eq("wr_data", 32'(bus.mem_wdata), 32'(w.data));
                check_eq("w_ack", 32'(bus.w_ack), 32'd1);
            end
        end else if (bus.w_ack) check_eq("w_ack_no_write", 32'(bus.w_ack), 32'd0);
        if (bus.fill_tag_we && !bus.fill_data_we) check_eq("tag_without_data", 32'd1, 32'(bus.fill_data_we));
        if (bus.fill_data_we) begin
            n_fdwe++;
            if (fill_q.size() == 0) check_eq("unexpected_fill", 32'(bus.fill_data), 32'hFFFFFFFF);
            else begin
                f = fill_q.pop_front();
                last_word = int'(f.word);
                check_eq("fill_sel", 32'(bus.fill_sel), 32'(f.sel));
                check_eq("fill_word", 32'(bus.fill_word), 32'(f.word));
                check_eq("fill_data", 32'(bus.fill_data), 32'(f.data));
                check_eq("fill_tag_we", 32'(bus.fill_tag_we), 32'(f.word == 3'd7));
            end
            if (bus.fill_tag_we) begin
                check_eq("fill_latency", 32'(cyc - first_issue), 32'(c_BW - 1 + c_LAT));
                check_eq("issue_count", 32'(n_issue), 32'(c_BW));
                if (bus.fill_sel == SEL_ICACHE) begin
                    check_eq("i_stall_drop", 32'(bus.i_stall), 32'd0);
                    bus.i_req = 1'b0;
                end else begin
                    check_eq("d_stall_drop", 32'(bus.d_stall), 32'(bus.w_req));
                    bus.d_req = 1'b0;
                end
                n_issue = 0;
                tag_cyc = cyc;
            end
        end
        if (bus.w_ack) bus.w_req = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_done();
        int n = 0;
        while ((fill_q.size() != 0 || wr_q.size() != 0 || bus.i_req || bus.d_req || bus.w_req) && n < 200) begin
            tick();
            n++;
        end
        check_eq("drain", 32'(fill_q.size() + wr_q.size()), 32'd0);
        tick();
    endtask

    task automatic wait_word(input int w);
        int n = 0;
        while (last_word != w && n < 100) begin
            tick();
            n++;
        end
        check_eq("wait_word", 32'(last_word), 32'(w));
    endtask

    initial begin
        int snap;
        bus.i_req = 1'b1; bus.i_addr = 16'h0;
        bus.d_req = 1'b0; bus.d_addr = 16'h0;
        bus.w_req = 1'b0; bus.w_addr = 16'h0; bus.w_data = 16'h0;

        #2 rst = 1'b0;
        #1;
        check_eq("rst_i_stall", 32'(bus.i_stall), 32'd0);
        check_eq("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_fill_we", 32'({bus.fill_data_we, bus.fill_tag_we, bus.w_ack, bus.fill_sel}), 32'd0);
        bus.i_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Instruction miss
        bus.i_req = 1'b1; bus.i_addr = 16'h1234;
        push_fill(SEL_ICACHE, 16'h1234, c_BW);
        tick(); tick(); tick();
        check_eq("i_stall_during_fill", 32'(bus.i_stall), 32'd1);
        check_eq("no_write_in_fill", 32'(bus.mem_wr), 32'd0);
        wait_done();

        // Write-through from idle
        bus.w_req = 1'b1; bus.w_addr = 16'h0040; bus.w_data = 16'hBEEF;
        wr_q.push_back('{addr: 16'h0040, data: 16'hBEEF});
        #1 check_eq("d_stall_write_pending", 32'(bus.d_stall), 32'd1);
        wait_done();
        check_eq("idle_mem_enable", 32'(bus.mem_enable), 32'd0);

        // Two back-to-back dual misses: D first each time
        for (int r = 0; r < 2; r++) begin
            bus.d_req = 1'b1; bus.d_addr = (r == 0) ? 16'h8ABC : 16'h3C0E;
            bus.i_req = 1'b1; bus.i_addr = (r == 0) ? 16'h0456 : 16'hF00A;
            push_fill(SEL_DCACHE, bus.d_addr, c_BW);
            push_fill(SEL_ICACHE, bus.i_addr, c_BW);
            wait_done();
        end

        // Write arriving mid-fill waits for the block to finish
        last_word = -1;
        bus.d_req = 1'b1; bus.d_addr = 16'h2468;
        push_fill(SEL_DCACHE, 16'h2468, c_BW);
        wait_word(3);
        bus.w_req = 1'b1; bus.w_addr = 16'h0A0C; bus.w_data = 16'h5AA5;
        wr_q.push_back('{addr: 16'h0A0C, data: 16'h5AA5});
        tick();
        check_eq("d_stall_write_held", 32'(bus.d_stall), 32'd1);
        check_eq("write_held_in_fill", 32'(bus.mem_wr), 32'd0);
        wait_done();
        check_eq("write_after_idle", 32'(write_cyc - tag_cyc), 32'd2);

        // Reset during a fill abandons it
        last_word = -1;
        bus.i_req = 1'b1; bus.i_addr = 16'h7F00;
        push_fill(SEL_ICACHE, 16'h7F00, 5);
        wait_word(4);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("abort_fill_we", 32'({bus.fill_data_we, bus.fill_tag_we}), 32'd0);
        check_eq("abort_mem_enable", 32'(bus.mem_enable), 32'd0);
        check_eq("abort_i_stall", 32'(bus.i_stall), 32'd0);
        check_eq("abort_fill_data", 32'(bus.fill_data), 32'd0);
        bus.i_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        snap = n_fdwe;
        repeat (8) tick();
        check_eq("stray_fill_we", 32'(n_fdwe - snap), 32'd0);
        check_eq("abort_queue", 32'(fill_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, meaning cycles from an issued read to its mem_valid.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8, meaning 16-bit words per cache block.
REQ-003 SHALL have ports:
  clk  in  1  clock, rising edge
  rst  in  1  asynchronous active-low reset
  i_req  in  1  I-cache miss pending
  i_addr  in  16  I-miss byte address
  d_req  in  1  D-cache miss pending
  d_addr  in  16  D-miss byte address
  w_req  in  1  D write-through pending
  w_addr  in  16  write byte address
  w_data  in  16  write data
  mem_addr  out  16  memory address
  mem_enable  out  1  memory access strobe
  mem_wr  out  1  memory write
  mem_wdata  out  16  memory write data
  mem_rdata  in  16  memory read data
  mem_valid  in  1  mem_rdata valid
  i_stall  out  1  I side stalled
  d_stall  out  1  D side stalled
  w_ack  out  1  one-cycle write-complete pulse
  fill_sel  out  1  0 = I-cache target, 1 = D-cache target
  fill_word  out  3  word offset being written
  fill_data  out  16  fill data (mem_rdata)
  fill_data_we  out  1  data-array write
  fill_tag_we  out  1  tag-array write

Function
REQ-004 SHALL implement states IDLE, FILL, WRITE.
REQ-005 IDLE: w_req -> WRITE; else d_req/i_req -> FILL per REQ-013; otherwise stay.
REQ-006 WRITE SHALL last one cycle: mem_enable=1, mem_wr=1, mem_addr=w_addr, mem_wdata=w_data, w_ack=1, then IDLE.
REQ-007 On FILL entry SHALL latch base = selected addr & 16'hFFF0 and fill_sel.
REQ-008 FILL SHALL issue BLOCK_WORDS reads on consecutive cycles, mem_addr = base + 2*k, k = 0..7, mem_enable=1, mem_wr=0.
REQ-009 Each mem_valid in FILL SHALL assert fill_data_we, with fill_data=mem_rdata and fill_word = return count (0..7), in the same cycle.
REQ-010 fill_tag_we SHALL assert with the 8th return only; FILL -> IDLE on the following edge.
REQ-011 Fill latency: issue to last fill_data_we = BLOCK_WORDS-1+MEM_LATENCY cycles (11 default).
REQ-012 mem_valid outside FILL SHALL be ignored; issue and return counters SHALL be 3-bit, no wrap past 7.
REQ-013 With both d_req and i_req in IDLE, D SHALL win (see REQ-019).
REQ-014 i_stall = i_req & not (FILL with fill_sel=0 and tag written this cycle); d_stall = d_req likewise for fill_sel=1, OR w_req & not w_ack.
REQ-015 Request drop during FILL SHALL NOT abort; block completes, tag written.
REQ-016 w_req during FILL SHALL wait, served first from next IDLE.
REQ-017 mem_enable/mem_wr SHALL be 0 in IDLE and after the 8th issue in FILL.

Reset
REQ-018 rst low SHALL force IDLE, clear counters and latched base/sel, and drive all outputs 0 immediately; a fill in progress is abandoned with no tag write; late mem_valid after release is ignored.

Configuration
REQ-019 With ARB_RR_EN defined, simultaneous d_req/i_req in IDLE SHALL go to the side not granted last fill (last-grant flop resets to I, so D wins first); without it, fixed D priority per REQ-013.

Structure
REQ-020 Shared package mem_pkg SHALL hold state enum, fill_sel encodings, BLOCK_MASK (16'hFFF0), default MEM_LATENCY/BLOCK_WORDS.
REQ-021 Sub-module fill_counter (issue/return counters, done flags) is natural; no other hierarchy.

Verification
REQ-022 i_req, i_addr=16'h1234, 4-cycle memory model -> reads 16'h1230..16'h123E; 8 fill_data_we with fill_sel=0, fill_word 0..7; fill_tag_we on the 8th; i_stall drops that cycle.
REQ-023 d_req and i_req same cycle, no macro -> D fill, then I fill; with ARB_RR_EN two back-to-back dual requests -> D, I, D, I.
REQ-024 w_req, w_addr=16'h0040, w_data=16'hBEEF in IDLE -> one cycle mem_wr=1 with those values, w_ack pulse.
REQ-025 w_req raised at fill return 3 -> write held, d_stall=1, WRITE occurs cycle after IDLE re-entry.
REQ-026 rst low at fill return 5 -> outputs 0 at once; no fill_tag_we; post-reset stray mem_valid -> no fill_data_we.
